uvmt_cv32e40x_obi_arbiter: RTL and testbench
============================================

Name: uvmt_cv32e40x_obi_arbiter

Overview:
- Two-master, one-slave OBI arbiter. Merges the core's instruction OBI port (read-only) and data OBI port onto a single shared OBI memory port.
- Testbench-side block, placed between the DUT wrapper's OBI interfaces and a single-ported memory model.
- Arbitration is round-robin with address-phase locking.
- Responses are routed in order using an owner FIFO.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
MAX_OUTSTANDING, 2, owner-FIFO depth, i.e. the maximum number of granted transactions without a response (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  instruction request
instr_gnt_o  out  1  instruction grant
instr_addr_i  in  ADDR_WIDTH  instruction address
instr_prot_i  in  3  instruction prot
instr_rvalid_o  out  1  instruction response valid
instr_rdata_o  out  DATA_WIDTH  instruction read data
instr_err_o  out  1  instruction bus error
data_req_i  in  1  data request
data_gnt_o  out  1  data grant
data_addr_i  in  ADDR_WIDTH  data address
data_we_i  in  1  write enable
data_be_i  in  DATA_WIDTH/8  byte enables
data_wdata_i  in  DATA_WIDTH  write data
data_prot_i  in  3  data prot
data_rvalid_o  out  1  data response valid
data_rdata_o  out  DATA_WIDTH  data read data
data_err_o  out  1  data bus error
mem_req_o  out  1  shared request
mem_gnt_i  in  1  shared grant
mem_addr_o  out  ADDR_WIDTH  shared address
mem_we_o  out  1  shared write enable
mem_be_o  out  DATA_WIDTH/8  shared byte enables
mem_wdata_o  out  DATA_WIDTH  shared write data
mem_prot_o  out  3  shared prot
mem_rvalid_i  in  1  shared response valid
mem_rdata_i  in  DATA_WIDTH  shared read data
mem_err_i  in  1  shared error
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current owner-FIFO occupancy
protocol_err_o  out  1  sticky: mem_rvalid_i seen with an empty FIFO

Behaviour:
Reset values (asynchronous, rst_ni=0):
- FIFO empty, outstanding_o=0, protocol_err_o=0, lock cleared, round-robin priority = instruction.
- With all inputs low, all outputs are 0.

Selection (combinational):
- If lock is set, the locked master is selected.
- Otherwise, if only one master requests, that master is selected.
- If both request, the priority master is selected.

Request path:
- mem_req_o = selected master's req AND NOT full.
- full is derived from the registered count only: count==MAX_OUTSTANDING blocks requests even if a pop occurs in the same cycle.

Address-phase muxing:
- mem_addr_o and mem_prot_o come from the selected master.
- When the instruction master is selected: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
- When no master is selected: address-phase outputs are 0.

Grant:
- x_gnt_o = mem_gnt_i AND mem_req_o AND (selected==x). Combinational, zero latency.
- The unselected master's gnt is always 0.

Lock:
- Set when mem_req_o=1 and mem_gnt_i=0. Holds the selection until the grant cycle.
- Cleared on the grant cycle.
- Also set when selected req=1 and full, so a master held off while full keeps its slot once the FIFO drains.

Round-robin update:
- On each accepted transfer (mem_req_o & mem_gnt_i), priority moves to the master that was not granted.

Owner FIFO:
- Push the owner bit on each accepted transfer.
- Pop on mem_rvalid_i when the FIFO is non-empty.
- Push and pop in the same cycle: count unchanged, order preserved.

Response routing:
- Head owner receives mem_rvalid_i, mem_rdata_i and mem_err_i, same cycle (combinational).
- The other master's rvalid=0 and its rdata/err=0.
- mem_rvalid_i with an empty FIFO: no rvalid to either master; protocol_err_o set, sticky until reset.
- Response in the same cycle as its own grant (zero-latency memory) is not permitted. The FIFO head is registered, so that rvalid counts as an empty-FIFO protocol error.

Reset mid-operation:
- Outstanding transactions are dropped. Later responses from memory raise protocol_err_o.

Test Plan:
- Only instr_req_i=1, addr 0x80, mem_gnt_i=1 every cycle, rvalid 1 cycle later with rdata 0xDEADBEEF -> instr_gnt_o=1 on cycle 0; instr_rvalid_o=1 with instr_rdata_o=0xDEADBEEF on cycle 1; data_rvalid_o=0; mem_be_o=0xF, mem_we_o=0.
- Both requesting continuously, mem_gnt_i=1, immediate responses -> grants alternate I,D,I,D starting with I after reset; responses routed to their owners in order.
- data_req_i=1, addr 0x1000, mem_gnt_i=0 for 3 cycles while instr_req_i rises in cycle 1 -> mem_addr_o stays 0x1000 until the grant; data_gnt_o is the first grant; instruction is granted next.
- MAX_OUTSTANDING=2, two grants with no rvalid -> mem_req_o=0 and outstanding_o=2; an rvalid arrives -> mem_req_o reasserts one cycle later and outstanding_o goes 2→1.
- mem_rvalid_i=1 with an empty FIFO -> no master rvalid; protocol_err_o=1 and held until rst_ni=0.
- mem_err_i=1 on a data read response -> data_err_o=1 with data_rvalid_o; instr_err_o stays 0.

Source files
------------

// File: rtl/uvmt_cv32e40x_obi_arbiter.sv
// Two-master, one-slave OBI arbiter: round-robin with address-phase locking,
// responses steered back to their requester through an in-order owner FIFO.
module uvmt_cv32e40x_obi_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
  localparam int BE_W           = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  input  logic [2:0]            instr_prot_i,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,

  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [BE_W-1:0]       data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [2:0]            data_prot_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,

  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [BE_W-1:0]       mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_prot_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,

  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  protocol_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {
    SEL_INSTR = 1'b0,
    SEL_DATA  = 1'b1
  } owner_e;

  owner_e              owner_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                lock_q, lock_d;
  owner_e              lock_owner_q, lock_owner_d;
  owner_e              prio_q, prio_d;
  logic                perr_q, perr_d;

  logic                sel_valid;
  owner_e              sel_owner;
  logic                sel_req;
  logic                full;
  logic                empty;
  logic                accept;
  logic                pop;
  owner_e              head_owner;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A held lock overrides arbitration so the address phase stays stable until granted.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = SEL_INSTR;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel_owner = lock_owner_q;
    end else if (instr_req_i && data_req_i) begin
      sel_valid = 1'b1;
      sel_owner = prio_q;
    end else if (instr_req_i) begin
      sel_valid = 1'b1;
      sel_owner = SEL_INSTR;
    end else if (data_req_i) begin
      sel_valid = 1'b1;
      sel_owner = SEL_DATA;
    end
  end

  assign sel_req   = sel_valid && ((sel_owner == SEL_DATA) ? data_req_i : instr_req_i);
  assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty     = (count_q == '0);
  assign mem_req_o = sel_req && !full;
  assign accept    = mem_req_o && mem_gnt_i;

  assign instr_gnt_o = accept && (sel_owner == SEL_INSTR);
  assign data_gnt_o  = accept && (sel_owner == SEL_DATA);

  always_comb begin
    mem_addr_o  = '0;
    mem_prot_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (sel_valid) begin
      if (sel_owner == SEL_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_prot_o  = data_prot_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_prot_o  = instr_prot_i;
        mem_be_o    = '1;
      end
    end
  end

  // The head is read from registered state only, so a same-cycle grant+rvalid sees an empty FIFO.
  assign pop        = mem_rvalid_i && !empty;
  assign head_owner = owner_q[rd_ptr_q];

  assign instr_rvalid_o = pop && (head_owner == SEL_INSTR);
  assign data_rvalid_o  = pop && (head_owner == SEL_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o  && mem_err_i;

  assign outstanding_o  = count_q;
  assign protocol_err_o = perr_q;

  always_comb begin
    lock_d       = 1'b0;
    lock_owner_d = lock_owner_q;
    if (!accept && sel_req) begin
      lock_d       = 1'b1;
      lock_owner_d = sel_owner;
    end
    prio_d   = accept ? ((sel_owner == SEL_DATA) ? SEL_INSTR : SEL_DATA) : prio_q;
    count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    perr_d   = perr_q || (mem_rvalid_i && empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_owner_q <= SEL_INSTR;
      prio_q       <= SEL_INSTR;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      perr_q       <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      prio_q       <= prio_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      perr_q       <= perr_d;
    end
  end

  // Storage needs no reset: entries are only read while the count marks them valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      owner_q[wr_ptr_q] <= sel_owner;
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_obi_arbiter.sv
// Directed bench for the OBI arbiter: a vector table walked cycle by cycle,
// then hand-written sequences for sticky error, async reset and zero-latency response.
module tb_uvmt_cv32e40x_obi_arbiter;

  localparam logic [3:0]  DBE    = 4'b0110;
  localparam logic [31:0] DWDATA = 32'hCAFE_0001;
  localparam logic [2:0]  IPROT  = 3'b101;
  localparam logic [2:0]  DPROT  = 3'b010;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic [2:0]  instr_prot_i;
  logic        instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic [2:0]  data_prot_i;
  logic        data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [2:0]  mem_prot_o;
  logic        mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  outstanding_o;
  logic        protocol_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uvmt_cv32e40x_obi_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_prot_i(instr_prot_i), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_prot_i(data_prot_i), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_prot_o(mem_prot_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i), .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  typedef struct {
    bit ireq; logic [31:0] iaddr; bit dreq; logic [31:0] daddr; bit dwe;
    bit gnt; bit rv; logic [31:0] rdata; bit err;
    bit e_ignt; bit e_dgnt; bit e_mreq; logic [31:0] e_maddr; bit e_mwe; logic [3:0] e_mbe;
    bit e_irv; bit e_drv; logic [1:0] e_out; bit e_perr;
  } vec_t;

  function automatic vec_t mk(bit ireq, logic [31:0] iaddr, bit dreq, logic [31:0] daddr,
                              bit dwe, bit gnt, bit rv, logic [31:0] rdata, bit err,
                              bit e_ignt, bit e_dgnt, bit e_mreq, logic [31:0] e_maddr,
                              bit e_mwe, logic [3:0] e_mbe, bit e_irv, bit e_drv,
                              logic [1:0] e_out, bit e_perr);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr; v.dwe = dwe;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
    v.e_ignt = e_ignt; v.e_dgnt = e_dgnt; v.e_mreq = e_mreq; v.e_maddr = e_maddr;
    v.e_mwe = e_mwe; v.e_mbe = e_mbe; v.e_irv = e_irv; v.e_drv = e_drv;
    v.e_out = e_out; v.e_perr = e_perr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                       input logic [31:0] daddr, input bit dwe, input bit gnt,
                       input bit rv, input logic [31:0] rdata, input bit err);
    instr_req_i  = ireq;  instr_addr_i = iaddr;
    data_req_i   = dreq;  data_addr_i  = daddr; data_we_i = dwe;
    mem_gnt_i    = gnt;   mem_rvalid_i = rv;    mem_rdata_i = rdata; mem_err_i = err;
  endtask

  vec_t tbl [23];

  initial begin
    // columns: ireq iaddr dreq daddr we gnt rv rdata err | ignt dgnt mreq maddr mwe mbe irv drv out perr
    // both requesting: I,D,I,D from reset, responses one cycle after each grant
    tbl[0]  = mk(1, 32'h100, 1, 32'h200, 1, 1, 0, 32'h0,        0, 1, 0, 1, 32'h100, 0, 4'hF, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'h104, 1, 32'h200, 1, 1, 1, 32'h11111111, 0, 0, 1, 1, 32'h200, 1, DBE,  1, 0, 1, 0);
    tbl[2]  = mk(1, 32'h104, 1, 32'h204, 0, 1, 1, 32'h22222222, 0, 1, 0, 1, 32'h104, 0, 4'hF, 0, 1, 1, 0);
    tbl[3]  = mk(1, 32'h108, 1, 32'h204, 0, 1, 1, 32'h33333333, 0, 0, 1, 1, 32'h204, 0, DBE,  1, 0, 1, 0);
    // data read response with bus error
    tbl[4]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h44444444, 1, 0, 0, 0, 32'h0,   0, 4'h0, 0, 1, 1, 0);
    // single instruction fetch
    tbl[5]  = mk(1, 32'h80,  0, 32'h0,   0, 1, 0, 32'h0,        0, 1, 0, 1, 32'h80,  0, 4'hF, 0, 0, 0, 0);
    tbl[6]  = mk(0, 32'h0,   0, 32'h0,   0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,   0, 4'h0, 1, 0, 1, 0);
    // data stalled three cycles, instruction arrives meanwhile and must wait
    tbl[7]  = mk(0, 32'h0,   1, 32'h1000,1, 0, 0, 32'h0,        0, 0, 0, 1, 32'h1000,1, DBE,  0, 0, 0, 0);
    tbl[8]  = mk(1, 32'h300, 1, 32'h1000,1, 0, 0, 32'h0,        0, 0, 0, 1, 32'h1000,1, DBE,  0, 0, 0, 0);
    tbl[9]  = mk(1, 32'h300, 1, 32'h1000,1, 0, 0, 32'h0,        0, 0, 0, 1, 32'h1000,1, DBE,  0, 0, 0, 0);
    tbl[10] = mk(1, 32'h300, 1, 32'h1000,1, 1, 0, 32'h0,        0, 0, 1, 1, 32'h1000,1, DBE,  0, 0, 0, 0);
    tbl[11] = mk(1, 32'h300, 0, 32'h0,   0, 1, 1, 32'h55555555, 0, 1, 0, 1, 32'h300, 0, 4'hF, 0, 1, 1, 0);
    tbl[12] = mk(0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h66666666, 0, 0, 0, 0, 32'h0,   0, 4'h0, 1, 0, 1, 0);
    // fill to two outstanding, requests held off, drain one, locked master proceeds
    tbl[13] = mk(0, 32'h0,   1, 32'h400, 0, 1, 0, 32'h0,        0, 0, 1, 1, 32'h400, 0, DBE,  0, 0, 0, 0);
    tbl[14] = mk(1, 32'h500, 0, 32'h0,   0, 1, 0, 32'h0,        0, 1, 0, 1, 32'h500, 0, 4'hF, 0, 0, 1, 0);
    tbl[15] = mk(1, 32'h504, 1, 32'h404, 0, 1, 0, 32'h0,        0, 0, 0, 0, 32'h404, 0, DBE,  0, 0, 2, 0);
    tbl[16] = mk(1, 32'h504, 1, 32'h404, 0, 1, 1, 32'h77777777, 0, 0, 0, 0, 32'h404, 0, DBE,  0, 1, 2, 0);
    tbl[17] = mk(1, 32'h504, 1, 32'h404, 0, 1, 0, 32'h0,        0, 0, 1, 1, 32'h404, 0, DBE,  0, 0, 1, 0);
    tbl[18] = mk(1, 32'h504, 0, 32'h0,   0, 1, 1, 32'h88888888, 0, 0, 0, 0, 32'h504, 0, 4'hF, 1, 0, 2, 0);
    tbl[19] = mk(1, 32'h504, 0, 32'h0,   0, 1, 1, 32'h99999999, 0, 1, 0, 1, 32'h504, 0, 4'hF, 0, 1, 1, 0);
    tbl[20] = mk(0, 32'h0,   0, 32'h0,   0, 0, 1, 32'hAAAAAAAA, 0, 0, 0, 0, 32'h0,   0, 4'h0, 1, 0, 1, 0);
    // response with nothing outstanding
    tbl[21] = mk(0, 32'h0,   0, 32'h0,   0, 0, 1, 32'hBBBBBBBB, 0, 0, 0, 0, 32'h0,   0, 4'h0, 0, 0, 0, 0);
    tbl[22] = mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 4'h0, 0, 0, 0, 1);

    // reset with every input low: every output low
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    instr_prot_i = '0; data_be_i = '0; data_wdata_i = '0; data_prot_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs",
        {instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, data_gnt_o, data_rvalid_o,
         data_rdata_o, data_err_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
         mem_prot_o, outstanding_o, protocol_err_o} == '0, 1);
    instr_prot_i = IPROT; data_be_i = DBE; data_wdata_i = DWDATA; data_prot_i = DPROT;
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 23; i++) begin
      vec_t v;
      v = tbl[i];
      @(negedge clk);
      drive(v.ireq, v.iaddr, v.dreq, v.daddr, v.dwe, v.gnt, v.rv, v.rdata, v.err);
      #1;
      chk($sformatf("v%0d_ignt", i),   instr_gnt_o,    v.e_ignt);
      chk($sformatf("v%0d_dgnt", i),   data_gnt_o,     v.e_dgnt);
      chk($sformatf("v%0d_mreq", i),   mem_req_o,      v.e_mreq);
      chk($sformatf("v%0d_maddr", i),  mem_addr_o,     v.e_maddr);
      chk($sformatf("v%0d_mwe", i),    mem_we_o,       v.e_mwe);
      chk($sformatf("v%0d_mbe", i),    mem_be_o,       v.e_mbe);
      chk($sformatf("v%0d_mwdata", i), mem_wdata_o,    (v.e_mbe == DBE) ? DWDATA : 32'h0);
      chk($sformatf("v%0d_mprot", i),  mem_prot_o,
          (v.e_mbe == DBE) ? DPROT : ((v.e_mbe == 4'hF) ? IPROT : 3'b000));
      chk($sformatf("v%0d_irv", i),    instr_rvalid_o, v.e_irv);
      chk($sformatf("v%0d_drv", i),    data_rvalid_o,  v.e_drv);
      chk($sformatf("v%0d_irdata", i), instr_rdata_o,  v.e_irv ? v.rdata : 32'h0);
      chk($sformatf("v%0d_drdata", i), data_rdata_o,   v.e_drv ? v.rdata : 32'h0);
      chk($sformatf("v%0d_ierr", i),   instr_err_o,    v.e_irv & v.err);
      chk($sformatf("v%0d_derr", i),   data_err_o,     v.e_drv & v.err);
      chk($sformatf("v%0d_out", i),    outstanding_o,  v.e_out);
      chk($sformatf("v%0d_perr", i),   protocol_err_o, v.e_perr);
    end

    // protocol error stays set until reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("perr_sticky%0d", i), protocol_err_o, 1);
    end
    rst_ni = 1'b0;
    #1;
    chk("perr_cleared_by_reset", protocol_err_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // asynchronous reset mid-operation drops the outstanding fetch
    @(negedge clk);
    drive(1, 32'h80, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("midrst_gnt", instr_gnt_o, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midrst_out_before", outstanding_o, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_out_async", outstanding_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0);
    #1;
    chk("midrst_late_irv", instr_rvalid_o, 0);
    chk("midrst_late_drv", data_rvalid_o, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midrst_late_perr", protocol_err_o, 1);

    // zero-latency response in the grant cycle is treated as an empty-FIFO response
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    drive(1, 32'h40, 0, 0, 0, 1, 1, 32'h0BADF00D, 0);
    #1;
    chk("zlat_gnt", instr_gnt_o, 1);
    chk("zlat_irv", instr_rvalid_o, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("zlat_perr", protocol_err_o, 1);
    chk("zlat_out", outstanding_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
